// File: rtl/unpack_yuv420.sv
// Unpacks 32-bit packed YUV420/422 words into one YUV pixel per clock, rebuilding
// 4:2:0 chroma from a line buffer. Optional build macro: UNPACK_UV_SIGNED_EN.
module unpack_yuv420 #(
  parameter int PIXEL_WIDTH = 8,
  parameter int MAX_COLS    = 1920,
  parameter int DTYPE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_420,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [31:0]            datai,
  output logic                   rdyo,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0] yo,
  output logic [PIXEL_WIDTH-1:0] uo,
  output logic [PIXEL_WIDTH-1:0] vo,
  output logic                   overflow
);

  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START = DTYPE_WIDTH'(1);
  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = DTYPE_WIDTH'(2);
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_START   = DTYPE_WIDTH'(3);
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END     = DTYPE_WIDTH'(4);
  localparam logic [DTYPE_WIDTH-1:0] DT_YUV         = DTYPE_WIDTH'(8);

  localparam int DEPTH = MAX_COLS / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(MAX_COLS + 5);

  localparam logic [CW-1:0] COL_MAX   = CW'(MAX_COLS);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

`ifdef UNPACK_UV_SIGNED_EN
  localparam logic [7:0] UV_XOR = 8'h80;
`else
  localparam logic [7:0] UV_XOR = 8'h00;
`endif

  // Serializer state: remaining items, Y bytes (head at [0]), chroma sources.
  logic [2:0]            count;
  logic [3:0][7:0]       y_sr;
  logic [15:0]           uv_word;
  logic [15:0]           uv_hold;
  logic [15:0]           rd_q;
  logic                  cur_marker;
  logic                  cur_yonly;
  logic [DTYPE_WIDTH-1:0] mk_dtype;

  // Frame / row context.
  logic                  en420_q;
  logic                  row_odd;
  logic                  row_ovf;
  logic                  overflow_q;
  logic [CW-1:0]         col;
  logic [AW-1:0]         addr_q;

  logic [15:0]           mem [DEPTH];

  logic                  accept;
  logic                  is_data;
  logic                  y_only;
  logic                  col_sat;
  logic                  col_full;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr0;
  logic [AW-1:0]         rd_addr1;
  logic [AW-1:0]         rd_addr;
  logic                  ld_y;
  logic                  rd_next;
  logic                  rd_en;
  logic                  wr_en;
  logic [CW-1:0]         col_step;
  logic [CW-1:0]         col_sum;
  logic [CW-1:0]         col_next;
  logic [15:0]           uv_cur;

  function automatic logic [PIXEL_WIDTH-1:0] expand(input logic [7:0] b);
    logic [PIXEL_WIDTH-1:0] r;
    r = '0;
    r[PIXEL_WIDTH-1 -: 8] = b;
    return r;
  endfunction

  assign rdyo     = (count <= 3'd1);
  assign accept   = dvi & rdyo;
  assign is_data  = (dtypei == DT_YUV);
  assign y_only   = en420_q & row_odd;
  assign col_sat  = (col >= COL_MAX);
  assign col_full = row_ovf | col_sat;
  assign wr_addr  = AW'(col >> 1);
  assign rd_addr0 = col_full ? ADDR_LAST : wr_addr;
  assign rd_addr1 = (addr_q == ADDR_LAST) ? ADDR_LAST : addr_q + AW'(1);

  // Entry 0 of a Y-only word is read on accept, entry 1 one cycle later.
  assign ld_y     = accept & is_data & y_only;
  assign rd_next  = cur_yonly & (count == 3'd4);
  assign rd_en    = ld_y | rd_next;
  assign rd_addr  = rd_next ? rd_addr1 : rd_addr0;
  assign wr_en    = accept & is_data & ~y_only & en420_q & ~col_full;

  assign col_step = y_only ? CW'(4) : CW'(2);
  assign col_sum  = col + col_step;
  assign col_next = (col_sum > COL_MAX) ? COL_MAX : col_sum;

  assign overflow = overflow_q;

  // NOTE: the line buffer and its read register have no reset so they map onto
  // block RAM; their contents are never observed until written or read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {datai[15:8], datai[31:24]};
    if (rd_en) rd_q <= mem[rd_addr];
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= 3'd0;
      y_sr       <= '0;
      uv_word    <= '0;
      uv_hold    <= '0;
      cur_marker <= 1'b0;
      cur_yonly  <= 1'b0;
      mk_dtype   <= '0;
      en420_q    <= 1'b0;
      row_odd    <= 1'b0;
      row_ovf    <= 1'b0;
      overflow_q <= 1'b0;
      col        <= '0;
      addr_q     <= '0;
    end else begin
      if (accept) begin
        if (is_data) begin
          cur_marker <= 1'b0;
          cur_yonly  <= y_only;
          col        <= col_next;
          if (y_only) begin
            count  <= 3'd4;
            y_sr   <= datai;
            addr_q <= rd_addr0;
          end else begin
            count   <= 3'd2;
            y_sr    <= {16'h0000, datai[23:16], datai[7:0]};
            uv_word <= {datai[15:8], datai[31:24]};
          end
          if (col_sat) begin
            overflow_q <= 1'b1;
            row_ovf    <= 1'b1;
          end
        end else begin
          count      <= 3'd1;
          cur_marker <= 1'b1;
          cur_yonly  <= 1'b0;
          mk_dtype   <= dtypei;
          case (dtypei)
            DT_FRAME_START: begin
              row_odd    <= 1'b0;
              overflow_q <= 1'b0;
              en420_q    <= enable_420;
            end
            DT_ROW_START: begin
              col     <= '0;
              row_ovf <= 1'b0;
            end
            DT_ROW_END:   row_odd <= ~row_odd;
            DT_FRAME_END: ;
            default:      ;
          endcase
        end
      end else if (count != 3'd0) begin
        count <= count - 3'd1;
        y_sr  <= {8'h00, y_sr[3:1]};
      end
      if (rd_next) uv_hold <= rd_q;
    end
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    dvo    = 1'b0;
    dtypeo = '0;
    yo     = '0;
    uo     = '0;
    vo     = '0;
    uv_cur = cur_yonly ? ((count == 3'd3) ? uv_hold : rd_q) : uv_word;
    if (count != 3'd0) begin
      dvo = 1'b1;
      if (cur_marker) begin
        dtypeo = mk_dtype;
      end else begin
        dtypeo = DT_YUV;
        yo     = expand(y_sr[0]);
        uo     = expand(uv_cur[15:8] ^ UV_XOR);
        vo     = expand(uv_cur[7:0] ^ UV_XOR);
      end
    end
  end

endmodule

// File: tb/tb_unpack_yuv420.sv
// Directed self-checking bench for unpack_yuv420 (MAX_COLS reduced to 8).
module tb_unpack_yuv420;

  localparam int PW = 8;
  localparam int MC = 8;
  localparam int DW = 4;

  localparam logic [3:0] FS  = 4'd1;
  localparam logic [3:0] FE  = 4'd2;
  localparam logic [3:0] RS  = 4'd3;
  localparam logic [3:0] RE  = 4'd4;
  localparam logic [3:0] YUV = 4'd8;

`ifdef UNPACK_UV_SIGNED_EN
  localparam logic [7:0] UVX = 8'h80;
`else
  localparam logic [7:0] UVX = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable_420 = 1'b0;
  logic          dvi = 1'b0;
  logic [DW-1:0] dtypei = '0;
  logic [31:0]   datai = '0;
  logic          rdyo;
  logic          dvo;
  logic [DW-1:0] dtypeo;
  logic [PW-1:0] yo, uo, vo;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_low = 0;
  int last_cyc = 0;
  logic [31:0] oq[$];
  int          cq[$];

  unpack_yuv420 #(.PIXEL_WIDTH(PW), .MAX_COLS(MC), .DTYPE_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .enable_420(enable_420), .dvi(dvi),
    .dtypei(dtypei), .datai(datai), .rdyo(rdyo), .dvo(dvo), .dtypeo(dtypeo),
    .yo(yo), .uo(uo), .vo(vo), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dvo) begin
      oq.push_back({dtypeo, 4'h0, yo, uo, vo});
      cq.push_back(cyc);
    end
    if (!rdyo) rdy_low++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] px(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    return {YUV, 4'h0, y, u ^ UVX, v ^ UVX};
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] dt);
    return {dt, 28'h0};
  endfunction

  task automatic send(input logic [3:0] dt, input logic [31:0] d);
    int n;
    n = 0;
    dvi = 1'b1;
    dtypei = dt;
    datai = d;
    @(negedge clk);
    while (!rdyo && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_rdy", {31'd0, rdyo}, 32'd1);
    @(posedge clk);
    #1;
    dvi = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    oq.delete();
    cq.delete();
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp, input bit contig);
    logic [31:0] obs;
    int c;
    obs = 32'hFFFF_FFFF;
    c = -100;
    if (oq.size() > 0) begin
      obs = oq.pop_front();
      c = cq.pop_front();
    end
    check(tag, obs, exp);
    if (contig) check({tag, "_gap"}, c - last_cyc, 32'd1);
    last_cyc = c;
  endtask

  initial begin
    int npix;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dvo", {31'd0, dvo}, 32'd0);
    check("rst_rdyo", {31'd0, rdyo}, 32'd1);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_dtype", {28'd0, dtypeo}, 32'd0);
    check("rst_yuv", {8'd0, yo, uo, vo}, 32'd0);
    reset = 1'b0;
    drain();

    // 4:2:2 frame: two chroma words, gapless output, one rdyo-low cycle per word.
    enable_420 = 1'b0;
    clear_q();
    rdy_low = 0;
    send(FS, 0); send(RS, 0);
    send(YUV, 32'h8020_4010); send(YUV, 32'h8122_4111);
    send(RE, 0); send(FE, 0);
    drain();
    check("t1_rdy_low", rdy_low, 32'd2);
    expect_out("t1_fs", mk(FS), 1'b0);
    expect_out("t1_rs", mk(RS), 1'b1);
    expect_out("t1_p0", px(8'h10, 8'h40, 8'h80), 1'b1);
    expect_out("t1_p1", px(8'h20, 8'h40, 8'h80), 1'b1);
    expect_out("t1_p2", px(8'h11, 8'h41, 8'h81), 1'b1);
    expect_out("t1_p3", px(8'h22, 8'h41, 8'h81), 1'b1);
    expect_out("t1_re", mk(RE), 1'b1);
    expect_out("t1_fe", mk(FE), 1'b1);
    check("t1_left", oq.size(), 32'd0);

    // 4:2:0 frame: Y-only row takes chroma from the line buffer; marker waits.
    enable_420 = 1'b1;
    clear_q();
    send(FS, 0); send(RS, 0);
    send(YUV, 32'h8020_4010); send(YUV, 32'h8122_4111);
    send(RE, 0); send(RS, 0);
    rdy_low = 0;
    send(YUV, 32'h0403_0201);
    send(RE, 0);
    check("t2_rdy_low", rdy_low, 32'd3);
    send(FE, 0);
    drain();
    expect_out("t2_fs", mk(FS), 1'b0);
    expect_out("t2_rs0", mk(RS), 1'b1);
    expect_out("t2_c0", px(8'h10, 8'h40, 8'h80), 1'b1);
    expect_out("t2_c1", px(8'h20, 8'h40, 8'h80), 1'b1);
    expect_out("t2_c2", px(8'h11, 8'h41, 8'h81), 1'b1);
    expect_out("t2_c3", px(8'h22, 8'h41, 8'h81), 1'b1);
    expect_out("t2_re0", mk(RE), 1'b1);
    expect_out("t2_rs1", mk(RS), 1'b1);
    expect_out("t2_y0", px(8'h01, 8'h40, 8'h80), 1'b1);
    expect_out("t2_y1", px(8'h02, 8'h40, 8'h80), 1'b1);
    expect_out("t2_y2", px(8'h03, 8'h41, 8'h81), 1'b1);
    expect_out("t2_y3", px(8'h04, 8'h41, 8'h81), 1'b1);
    expect_out("t2_re1", mk(RE), 1'b1);
    expect_out("t2_fe", mk(FE), 1'b1);

    // Row length: exactly MAX_COLS is fine, MAX_COLS+2 sets sticky overflow.
    enable_420 = 1'b0;
    clear_q();
    send(FS, 0); send(RS, 0);
    for (int i = 0; i < MC / 2; i++) send(YUV, 32'h8020_4010 + i);
    drain();
    check("t3_ovf_full_row", {31'd0, overflow}, 32'd0);
    send(YUV, 32'h8020_4010);
    send(RE, 0);
    drain();
    check("t3_ovf_set", {31'd0, overflow}, 32'd1);
    npix = 0;
    foreach (oq[i]) if (oq[i][31:28] == YUV) npix++;
    check("t3_pixels", npix, MC + 2);
    send(FS, 0);
    drain();
    check("t3_ovf_clr", {31'd0, overflow}, 32'd0);

    // Reset while a Y-only word is mid-serialisation, then a clean frame.
    enable_420 = 1'b1;
    send(FS, 0); send(RS, 0);
    send(YUV, 32'h8020_4010);
    send(RE, 0); send(RS, 0);
    send(YUV, 32'h0403_0201);
    @(posedge clk);
    #1;
    check("t4_mid_dvo", {31'd0, dvo}, 32'd1);
    check("t4_mid_rdyo", {31'd0, rdyo}, 32'd0);
    reset = 1'b1;
    #1;
    check("t4_rst_dvo", {31'd0, dvo}, 32'd0);
    check("t4_rst_rdyo", {31'd0, rdyo}, 32'd1);
    check("t4_rst_dtype", {28'd0, dtypeo}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_q();
    enable_420 = 1'b0;
    send(FS, 0); send(RS, 0);
    send(YUV, 32'h7F33_8030);
    send(RE, 0); send(FE, 0);
    drain();
    expect_out("t4_fs", mk(FS), 1'b0);
    expect_out("t4_rs", mk(RS), 1'b1);
    expect_out("t4_p0", px(8'h30, 8'h80, 8'h7F), 1'b1);
    expect_out("t4_p1", px(8'h33, 8'h80, 8'h7F), 1'b1);
    expect_out("t4_re", mk(RE), 1'b1);
    expect_out("t4_fe", mk(FE), 1'b1);
    check("t4_left", oq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
